// File: rtl/dmem_pkg.sv
// Shared types and constants for the dmem_ctrl data-memory stage.
// Optional macro DMEM_BYTE_WR_EN (byte-lane stores) is handled in dmem_array and dmem_ctrl.
package dmem_pkg;

   localparam int WORD_W     = 32;
   localparam int WAIT_CNT_W = 4;

   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE   = 2'd0;
   localparam state_t ST_WAIT   = 2'd1;
   localparam state_t ST_ACCESS = 2'd2;
   localparam state_t ST_RESP   = 2'd3;

   function automatic logic is_misaligned(input logic [1:0] byte_off);
      return |byte_off;
   endfunction

endpackage

// File: rtl/dmem_array.sv
// Synchronous single-port word RAM with a registered, clearable read port.
// With DMEM_BYTE_WR_EN defined, a per-lane write mask (be) is added.
module dmem_array #(
   parameter int ADDR_W = 10,
   parameter int WORD_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic              re,
   input  logic              clr,
   input  logic [ADDR_W-1:0] addr,
   input  logic [WORD_W-1:0] wdata,
`ifdef DMEM_BYTE_WR_EN
   input  logic [WORD_W/8-1:0] be,
`endif
   output logic [WORD_W-1:0] rdata
);

   logic [WORD_W-1:0]   mem [2**ADDR_W];
   logic [WORD_W/8-1:0] lane_en;

`ifdef DMEM_BYTE_WR_EN
   assign lane_en = be;
`else
   assign lane_en = '1;
`endif

   // NOTE: the storage array is deliberately left out of reset so it maps onto a RAM macro.
   always_ff @(posedge clk) begin
      for (int i = 0; i < WORD_W/8; i++) begin
         if (we && lane_en[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
   end

   // Read register doubles as the block's Dout, so it carries reset and a clear for misaligned responses.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rdata <= '0;
      end else if (clr) begin
         rdata <= '0;
      end else if (re) begin
         rdata <= mem[addr];
      end
   end

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory stage: valid/ready request, fixed wait states, one-cycle response pulse.
// Define DMEM_BYTE_WR_EN to add the ByteEn store-lane mask input.
module dmem_ctrl import dmem_pkg::*; #(
   parameter int ADDR_W   = 10,
   parameter int WAIT_CYC = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        MemWr,
   input  logic [31:0] Addr,
   input  logic [31:0] DataIn,
`ifdef DMEM_BYTE_WR_EN
   input  logic [3:0]  ByteEn,
`endif
   output logic        resp_valid,
   output logic [31:0] Dout,
   output logic        misalign
);

   localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD =
      (WAIT_CYC == 0) ? '0 : WAIT_CNT_W'(WAIT_CYC - 1);

   state_t                  state;
   logic [WAIT_CNT_W-1:0]   wait_cnt;
   logic                    wr_q;
   logic [ADDR_W-1:0]       word_q;
   logic [WORD_W-1:0]       data_q;
   logic                    accept;
   logic                    acc_misaligned;
   logic                    unused_addr_hi;

`ifdef DMEM_BYTE_WR_EN
   logic [3:0] be_q;
`endif

   // High address bits alias onto the RAM and are intentionally dropped.
   assign unused_addr_hi = ^Addr[31:ADDR_W+2];

   assign req_ready      = (state == ST_IDLE) && !rst;
   assign accept         = req_valid && req_ready;
   assign acc_misaligned = accept && is_misaligned(Addr[1:0]);
   assign resp_valid     = (state == ST_RESP);

   // NOTE: all state here uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= ST_IDLE;
         wait_cnt <= '0;
         misalign <= 1'b0;
         wr_q     <= 1'b0;
         word_q   <= '0;
         data_q   <= '0;
`ifdef DMEM_BYTE_WR_EN
         be_q     <= '0;
`endif
      end else begin
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  wr_q   <= MemWr;
                  word_q <= Addr[ADDR_W+1:2];
                  data_q <= DataIn;
`ifdef DMEM_BYTE_WR_EN
                  be_q   <= ByteEn;
`endif
                  if (acc_misaligned) begin
                     misalign <= 1'b1;
                     state    <= ST_RESP;
                  end else if (WAIT_CYC == 0) begin
                     state    <= ST_ACCESS;
                  end else begin
                     wait_cnt <= WAIT_LOAD;
                     state    <= ST_WAIT;
                  end
               end
            end
            ST_WAIT: begin
               if (wait_cnt == '0) state <= ST_ACCESS;
               else                wait_cnt <= wait_cnt - 1'b1;
            end
            ST_ACCESS: begin
               misalign <= 1'b0;
               state    <= ST_RESP;
            end
            ST_RESP: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   // A store still waiting when reset hits never reaches ACCESS, so the RAM is untouched.
   dmem_array #(
      .ADDR_W (ADDR_W),
      .WORD_W (WORD_W)
   ) u_array (
      .clk   (clk),
      .rst   (rst),
      .we    ((state == ST_ACCESS) && wr_q),
      .re    ((state == ST_ACCESS) && !wr_q),
      .clr   (acc_misaligned),
      .addr  (word_q),
      .wdata (data_q),
`ifdef DMEM_BYTE_WR_EN
      .be    (be_q),
`endif
      .rdata (Dout)
   );

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl: one instance with WAIT_CYC=2, one with WAIT_CYC=0.
// Byte-lane steps run only when DMEM_BYTE_WR_EN is defined.
module tb_dmem_ctrl;

   logic        clk = 1'b0;
   logic        rst;

   logic        req_valid_a, req_ready_a, mem_wr_a, resp_valid_a, misalign_a;
   logic [31:0] addr_a, data_in_a, dout_a;
   logic [3:0]  byte_en_a;

   logic        req_valid_z, req_ready_z, mem_wr_z, resp_valid_z, misalign_z;
   logic [31:0] addr_z, data_in_z, dout_z;
   logic [3:0]  byte_en_z;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   dmem_ctrl #(.ADDR_W(10), .WAIT_CYC(2)) u_dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid_a),
      .req_ready  (req_ready_a),
      .MemWr      (mem_wr_a),
      .Addr       (addr_a),
      .DataIn     (data_in_a),
`ifdef DMEM_BYTE_WR_EN
      .ByteEn     (byte_en_a),
`endif
      .resp_valid (resp_valid_a),
      .Dout       (dout_a),
      .misalign   (misalign_a)
   );

   dmem_ctrl #(.ADDR_W(10), .WAIT_CYC(0)) u_dut0 (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid_z),
      .req_ready  (req_ready_z),
      .MemWr      (mem_wr_z),
      .Addr       (addr_z),
      .DataIn     (data_in_z),
`ifdef DMEM_BYTE_WR_EN
      .ByteEn     (byte_en_z),
`endif
      .resp_valid (resp_valid_z),
      .Dout       (dout_z),
      .misalign   (misalign_z)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One request on the WAIT_CYC=2 instance; exp_k is the number of negedges from accept to response.
   task automatic req_a(input string tag, input logic wr, input logic [31:0] addr,
                        input logic [31:0] data, input logic [3:0] be, input int exp_k,
                        input logic [31:0] exp_dout, input logic exp_mis);
      int k;
      int low;
      @(negedge clk);
      check({tag, ":ready_before"}, 32'(req_ready_a), 32'd1);
      req_valid_a = 1'b1;
      mem_wr_a    = wr;
      addr_a      = addr;
      data_in_a   = data;
      byte_en_a   = be;
      @(posedge clk);
      #1;
      req_valid_a = 1'b0;
      data_in_a   = 32'h0;
      k   = 0;
      low = 0;
      while (k < 40) begin
         @(negedge clk);
         k++;
         if (req_ready_a === 1'b0) low++;
         if (resp_valid_a === 1'b1) break;
      end
      check({tag, ":latency"},   32'(k),          32'(exp_k));
      check({tag, ":ready_low"}, 32'(low),        32'(exp_k));
      check({tag, ":dout"},      dout_a,          exp_dout);
      check({tag, ":misalign"},  32'(misalign_a), 32'(exp_mis));
      @(negedge clk);
      check({tag, ":resp_pulse"},  32'(resp_valid_a), 32'd0);
      check({tag, ":ready_after"}, 32'(req_ready_a),  32'd1);
      check({tag, ":mis_hold"},    32'(misalign_a),   32'(exp_mis));
      check({tag, ":dout_hold"},   dout_a,            exp_dout);
   endtask

   initial begin
      rst         = 1'b1;
      req_valid_a = 1'b0; mem_wr_a = 1'b0; addr_a = '0; data_in_a = '0; byte_en_a = 4'hF;
      req_valid_z = 1'b0; mem_wr_z = 1'b0; addr_z = '0; data_in_z = '0; byte_en_z = 4'hF;

      // Reset and idle.
      @(negedge clk);
      @(negedge clk);
      check("rst:ready_a", 32'(req_ready_a), 32'd0);
      check("rst:ready_z", 32'(req_ready_z), 32'd0);
      rst = 1'b0;
      @(negedge clk);
      check("idle:ready",    32'(req_ready_a),  32'd1);
      check("idle:resp",     32'(resp_valid_a), 32'd0);
      check("idle:dout",     dout_a,            32'h0);
      check("idle:misalign", 32'(misalign_a),   32'd0);

      // Store / load / misaligned / aliasing.
      req_a("st10",   1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 4, 32'h0000_0000, 1'b0);
      req_a("ld10",   1'b0, 32'h0000_0010, 32'h0,         4'hF, 4, 32'hDEAD_BEEF, 1'b0);
      req_a("ld13",   1'b0, 32'h0000_0013, 32'h0,         4'hF, 1, 32'h0000_0000, 1'b1);
      req_a("ld10b",  1'b0, 32'h0000_0010, 32'h0,         4'hF, 4, 32'hDEAD_BEEF, 1'b0);
      req_a("st1004", 1'b1, 32'h0000_1004, 32'h1234_5678, 4'hF, 4, 32'hDEAD_BEEF, 1'b0);
      req_a("ld04",   1'b0, 32'h0000_0004, 32'h0,         4'hF, 4, 32'h1234_5678, 1'b0);
      req_a("st20",   1'b1, 32'h0000_0020, 32'h1111_1111, 4'hF, 4, 32'h1234_5678, 1'b0);

      // Reset while a store is in WAIT: the store must be discarded.
      @(negedge clk);
      req_valid_a = 1'b1; mem_wr_a = 1'b1; addr_a = 32'h20; data_in_a = 32'hAAAA_5555;
      @(posedge clk);
      #1;
      req_valid_a = 1'b0;
      @(negedge clk);
      check("midrst:busy", 32'(req_ready_a), 32'd0);
      rst = 1'b1;
      #1;
      check("midrst:ready",    32'(req_ready_a),  32'd0);
      check("midrst:resp",     32'(resp_valid_a), 32'd0);
      check("midrst:dout",     dout_a,            32'h0);
      check("midrst:misalign", 32'(misalign_a),   32'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      req_a("ld20",    1'b0, 32'h0000_0020, 32'h0,         4'hF, 4, 32'h1111_1111, 1'b0);
      req_a("st22mis", 1'b1, 32'h0000_0022, 32'hBADB_AD00, 4'hF, 1, 32'h0000_0000, 1'b1);
      req_a("ld20b",   1'b0, 32'h0000_0020, 32'h0,         4'hF, 4, 32'h1111_1111, 1'b0);

`ifdef DMEM_BYTE_WR_EN
      req_a("be_init", 1'b1, 32'h0000_0030, 32'h1111_1111, 4'hF,    4, 32'h1111_1111, 1'b0);
      req_a("be_st",   1'b1, 32'h0000_0030, 32'hFFFF_FFFF, 4'b0010, 4, 32'h1111_1111, 1'b0);
      req_a("be_ld",   1'b0, 32'h0000_0030, 32'h0,         4'b0000, 4, 32'h1111_FF11, 1'b0);
      req_a("be_none", 1'b1, 32'h0000_0030, 32'h0000_0000, 4'b0000, 4, 32'h1111_FF11, 1'b0);
      req_a("be_ld2",  1'b0, 32'h0000_0030, 32'h0,         4'hF,    4, 32'h1111_FF11, 1'b0);
`endif

      // WAIT_CYC=0, req_valid held high: accepts at negedge 0, 3, 6; responses at 2, 5, 8.
      @(negedge clk);
      req_valid_z = 1'b1; mem_wr_z = 1'b1; addr_z = 32'h40; data_in_z = 32'hCAFE_F00D;
      for (int n = 0; n < 9; n++) begin
         check($sformatf("b2b:ready%0d", n), 32'(req_ready_z),  32'((n % 3) == 0));
         check($sformatf("b2b:resp%0d", n),  32'(resp_valid_z), 32'((n % 3) == 2));
         if (n == 1) begin
            mem_wr_z  = 1'b0;
            data_in_z = 32'h0;
            addr_z    = 32'h41;
         end
         if (n == 2) begin
            addr_z = 32'h40;
            check("b2b:st_dout", dout_z,            32'h0);
            check("b2b:st_mis",  32'(misalign_z),   32'd0);
         end
         if (n == 5 || n == 8) begin
            check($sformatf("b2b:ld_dout%0d", n), dout_z,          32'hCAFE_F00D);
            check($sformatf("b2b:ld_mis%0d", n),  32'(misalign_z), 32'd0);
         end
         @(negedge clk);
      end
      req_valid_z = 1'b0;
      @(negedge clk);
      check("b2b:idle_ready", 32'(req_ready_z),  32'd1);
      check("b2b:idle_resp",  32'(resp_valid_z), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
